snake_move_unit: RTL and testbench
==================================

# snake_move_unit

Snake datapath for the greedy-snake game. Holds the body segment coordinates and latches direction keys. Advances the snake one grid cell per move tick while the game is in PLAY, and reports collisions back to the game controller on hit_wall/hit_body. It consumes the controller's game_status/restart outputs and feeds the renderer with head/body coordinates.

## Interface
- GRID_W, 40, playfield width in cells; x in 0..GRID_W-1
- GRID_H, 30, playfield height in cells; y in 0..GRID_H-1
- MAX_LEN, 16, maximum segment count
- INIT_LEN, 3, length after reset/restart (2..MAX_LEN)
- MOVE_TICKS, 12_500_000, clk cycles per move step (4 steps/s at 50 MHz)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- game_status  in  2  00 RESTART, 01 START, 10 PLAY, 11 DIE
- restart  in  1  active-low reinit request from controller
- key1_press..key4_press  in  1 each  single-cycle presses: up, down, left, right
- apple_x  in  6  apple cell x
- apple_y  in  5  apple cell y
- head_x  out  6  segment 0 x
- head_y  out  5  segment 0 y
- body_x  out  6*MAX_LEN  flattened segment x; segment i at bits [6i+5:6i]
- body_y  out  5*MAX_LEN  flattened segment y; segment i at bits [5i+4:5i]
- snake_len  out  5  valid segment count
- hit_wall  out  1  level; next step would leave the grid
- hit_body  out  1  level; next step lands on own body
- apple_eaten  out  1  1-cycle pulse on a growth step
- move_tick  out  1  1-cycle pulse on every step attempt

## Operation
- Init state (reset or restart==0):
  - Head at (GRID_W/2, GRID_H/2).
  - Segment i at (GRID_W/2-i, GRID_H/2) for i<INIT_LEN; all other segments equal the head.
  - dir = cur_dir = pending = RIGHT; snake_len = INIT_LEN.
  - hit_* = 0, apple_eaten = 0, move_tick = 0, tick counter = 0.
- restart==0 overrides all other activity in any game_status.
- Direction latch:
  - Runs in every status except while restart==0.
  - Simultaneous presses resolve by priority key1 > key2 > key3 > key4.
  - A press opposite to cur_dir (the direction of the last executed step) is ignored.
  - Otherwise pending ← pressed direction; the latest accepted press wins.
- Tick counter:
  - Counts 0..MOVE_TICKS-1 only in PLAY; held at 0 in any other status.
  - At MOVE_TICKS-1 it wraps and issues a step.
- Step sequence, evaluated against pending:
  1. Wall check with no wrap-around: UP at y=0, DOWN at y=GRID_H-1, LEFT at x=0, RIGHT at x=GRID_W-1 → hit_wall ← 1; no movement. Compare before arithmetic; never form x-1 at 0.
  2. Body check: next head equal to any segment 1..snake_len-2, or 1..snake_len-1 when eating, → hit_body ← 1; no movement. The tail cell is legal when not growing.
  3. Move: seg[i] ← seg[i-1] for i≥1, seg[0] ← next head, cur_dir ← pending.
  4. Eat: next head == (apple_x, apple_y) → snake_len+1 (saturating at MAX_LEN, where the tail is dropped) and apple_eaten pulse.
- hit_wall/hit_body hold until init. No further steps run once either is set, because the controller leaves PLAY.

## Timing
- All outputs registered; reset values as in init state.
- Step effects (new segments, snake_len, hit_*, apple_eaten) appear in the cycle after the counter reaches MOVE_TICKS-1. move_tick pulses in that same cycle.
- A key press in cycle n is visible in pending at n+1 and affects a step issued at n+1 or later.
- Leaving PLAY mid-count discards the partial count; re-entry starts a full MOVE_TICKS period.
- restart low for ≥1 cycle yields init state on the next edge. It is idempotent while held low.
- Wall and body conditions in the same step (impossible geometrically): hit_wall takes precedence.

## Structure
- Shared package snake_pkg holds:
  - game-status encodings (RESTART/START/PLAY/DIE)
  - direction encoding (UP=0, DOWN=1, LEFT=2, RIGHT=3) and its opposite function
  - coordinate widths X_W=6, Y_W=5
- Sub-module snake_tick_gen: a MOVE_TICKS counter with enable and synchronous clear, emitting the step pulse.
- Segment storage is a register array in this block; the collision compare is a parallel loop over MAX_LEN gated by snake_len.

## Test plan
Bench parameters: GRID_W=8, GRID_H=8, MAX_LEN=6, MOVE_TICKS=4, apple at (7,7) unless stated.
- Reset then status=PLAY, no keys → head (4,4)→(5,4)→(6,4)→(7,4) on steps 1-3; step 4 sets hit_wall=1 with head held at (7,4); move_tick pulses every 4 cycles.
- In START, key2 pulsed, then PLAY → first step head (4,5); then key1 (reverse of DOWN) → ignored, next head (4,6).
- Apple at (5,4), PLAY → step 1 head (5,4), apple_eaten=1 for one cycle, snake_len 3→4, segment 3 = (2,4).
- Grow to length 5, then steer RIGHT→DOWN→LEFT→UP (press before each step) → hit_body=1 on the UP step with no movement; with length 4 on the same path, the head enters the vacated tail cell and no hit occurs.
- status forced to DIE mid-count then back to PLAY → next step occurs exactly 4 cycles after re-entry; restart=0 for one cycle → head (4,4), snake_len=3, hit_*=0.
- key1 and key4 pulsed in the same cycle → pending=UP.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared encodings for the greedy-snake datapath: game status, move direction
// and coordinate widths.
package snake_pkg;

    localparam int X_W   = 6;
    localparam int Y_W   = 5;
    localparam int LEN_W = 5;

    typedef enum logic [1:0] {
        ST_RESTART = 2'b00,
        ST_START   = 2'b01,
        ST_PLAY    = 2'b10,
        ST_DIE     = 2'b11
    } game_status_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    function automatic dir_e opposite_dir(input dir_e d);
        case (d)
            DIR_UP:   return DIR_DOWN;
            DIR_DOWN: return DIR_UP;
            DIR_LEFT: return DIR_RIGHT;
            default:  return DIR_LEFT;
        endcase
    endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Move-step timebase: counts 0..MOVE_TICKS-1 while enabled and pulses step_o
// in the cycle the count sits at its last value.
module snake_tick_gen #(
    parameter int MOVE_TICKS = 12_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic step_o
);

    localparam int CNT_W = (MOVE_TICKS > 1) ? $clog2(MOVE_TICKS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MOVE_TICKS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign step_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/snake_move_unit.sv
// Snake body datapath: segment registers, direction latch, per-step wall/body
// collision checks and growth on apple hits.
module snake_move_unit
    import snake_pkg::*;
#(
    parameter int GRID_W     = 40,
    parameter int GRID_H     = 30,
    parameter int MAX_LEN    = 16,
    parameter int INIT_LEN   = 3,
    parameter int MOVE_TICKS = 12_500_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           game_status,
    input  logic                 restart,
    input  logic                 key1_press,
    input  logic                 key2_press,
    input  logic                 key3_press,
    input  logic                 key4_press,
    input  logic [X_W-1:0]       apple_x,
    input  logic [Y_W-1:0]       apple_y,
    output logic [X_W-1:0]       head_x,
    output logic [Y_W-1:0]       head_y,
    output logic [X_W*MAX_LEN-1:0] body_x,
    output logic [Y_W*MAX_LEN-1:0] body_y,
    output logic [LEN_W-1:0]     snake_len,
    output logic                 hit_wall,
    output logic                 hit_body,
    output logic                 apple_eaten,
    output logic                 move_tick
);

    localparam logic [X_W-1:0]   X_MAX = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0]   Y_MAX = Y_W'(GRID_H - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_INIT = LEN_W'(INIT_LEN);

    function automatic logic [X_W-1:0] init_x(input int i);
        return (i < INIT_LEN) ? X_W'(GRID_W / 2 - i) : X_W'(GRID_W / 2);
    endfunction

    logic [X_W-1:0]   seg_x_q [MAX_LEN];
    logic [X_W-1:0]   seg_x_d [MAX_LEN];
    logic [Y_W-1:0]   seg_y_q [MAX_LEN];
    logic [Y_W-1:0]   seg_y_d [MAX_LEN];
    logic [LEN_W-1:0] len_q, len_d;
    dir_e             cur_dir_q, cur_dir_d;
    dir_e             pending_q, pending_d;
    logic             hit_wall_q, hit_wall_d;
    logic             hit_body_q, hit_body_d;
    logic             eaten_q, eaten_d;
    logic             tick_q, tick_d;

    logic             play_run;
    logic             step;
    logic             key_vld;
    dir_e             key_dir;
    logic             wall;
    logic             body;
    logic             eat;
    logic [X_W-1:0]   nhx;
    logic [Y_W-1:0]   nhy;
    logic [LEN_W-1:0] body_lim;

    assign play_run = (game_status == ST_PLAY) && restart;

    snake_tick_gen #(
        .MOVE_TICKS(MOVE_TICKS)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (play_run),
        .clr_i  (!play_run),
        .step_o (step)
    );

    always_comb begin
        seg_x_d    = seg_x_q;
        seg_y_d    = seg_y_q;
        len_d      = len_q;
        cur_dir_d  = cur_dir_q;
        pending_d  = pending_q;
        hit_wall_d = hit_wall_q;
        hit_body_d = hit_body_q;
        eaten_d    = 1'b0;
        tick_d     = step;
        key_vld    = key1_press | key2_press | key3_press | key4_press;
        key_dir    = DIR_RIGHT;
        wall       = 1'b0;
        body       = 1'b0;
        nhx        = seg_x_q[0];
        nhy        = seg_y_q[0];

        if (key1_press)      key_dir = DIR_UP;
        else if (key2_press) key_dir = DIR_DOWN;
        else if (key3_press) key_dir = DIR_LEFT;
        if (key_vld && key_dir != opposite_dir(cur_dir_q)) pending_d = key_dir;

        // Edge test precedes arithmetic so no coordinate ever wraps.
        case (pending_q)
            DIR_UP:   begin wall = (seg_y_q[0] == '0);   if (!wall) nhy = seg_y_q[0] - Y_W'(1); end
            DIR_DOWN: begin wall = (seg_y_q[0] == Y_MAX); if (!wall) nhy = seg_y_q[0] + Y_W'(1); end
            DIR_LEFT: begin wall = (seg_x_q[0] == '0);   if (!wall) nhx = seg_x_q[0] - X_W'(1); end
            default:  begin wall = (seg_x_q[0] == X_MAX); if (!wall) nhx = seg_x_q[0] + X_W'(1); end
        endcase

        eat = (nhx == apple_x) && (nhy == apple_y);
        // The tail moves away this step unless the snake grows into it.
        body_lim = eat ? len_q - LEN_W'(1) : len_q - LEN_W'(2);
        for (int i = 1; i < MAX_LEN; i++) begin
            if (LEN_W'(i) <= body_lim && seg_x_q[i] == nhx && seg_y_q[i] == nhy) body = 1'b1;
        end

        if (step && !hit_wall_q && !hit_body_q) begin
            if (wall) begin
                hit_wall_d = 1'b1;
            end else if (body) begin
                hit_body_d = 1'b1;
            end else begin
                for (int i = 1; i < MAX_LEN; i++) begin
                    seg_x_d[i] = seg_x_q[i-1];
                    seg_y_d[i] = seg_y_q[i-1];
                end
                seg_x_d[0] = nhx;
                seg_y_d[0] = nhy;
                cur_dir_d  = pending_q;
                if (eat) begin
                    eaten_d = 1'b1;
                    if (len_q != LEN_MAX) len_d = len_q + LEN_W'(1);
                end
            end
        end

        if (!restart) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_d[i] = init_x(i);
                seg_y_d[i] = Y_W'(GRID_H / 2);
            end
            len_d      = LEN_INIT;
            cur_dir_d  = DIR_RIGHT;
            pending_d  = DIR_RIGHT;
            hit_wall_d = 1'b0;
            hit_body_d = 1'b0;
            eaten_d    = 1'b0;
            tick_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= init_x(i);
                seg_y_q[i] <= Y_W'(GRID_H / 2);
            end
            len_q      <= LEN_INIT;
            cur_dir_q  <= DIR_RIGHT;
            pending_q  <= DIR_RIGHT;
            hit_wall_q <= 1'b0;
            hit_body_q <= 1'b0;
            eaten_q    <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            seg_x_q    <= seg_x_d;
            seg_y_q    <= seg_y_d;
            len_q      <= len_d;
            cur_dir_q  <= cur_dir_d;
            pending_q  <= pending_d;
            hit_wall_q <= hit_wall_d;
            hit_body_q <= hit_body_d;
            eaten_q    <= eaten_d;
            tick_q     <= tick_d;
        end
    end

    for (genvar g = 0; g < MAX_LEN; g++) begin : g_flat
        assign body_x[X_W*g +: X_W] = seg_x_q[g];
        assign body_y[Y_W*g +: Y_W] = seg_y_q[g];
    end

    assign head_x      = seg_x_q[0];
    assign head_y      = seg_y_q[0];
    assign snake_len   = len_q;
    assign hit_wall    = hit_wall_q;
    assign hit_body    = hit_body_q;
    assign apple_eaten = eaten_q;
    assign move_tick   = tick_q;

endmodule

// File: tb/tb_snake_move_unit.sv
// Directed bench for snake_move_unit on an 8x8 grid, MAX_LEN=6, MOVE_TICKS=4.
module tb_snake_move_unit;

    localparam int MAX_LEN = 6;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [1:0]           game_status = 2'b00;
    logic                 restart = 1'b1;
    logic                 key1_press = 1'b0, key2_press = 1'b0, key3_press = 1'b0, key4_press = 1'b0;
    logic [5:0]           apple_x = 6'd7;
    logic [4:0]           apple_y = 5'd7;
    logic [5:0]           head_x;
    logic [4:0]           head_y;
    logic [6*MAX_LEN-1:0] body_x;
    logic [5*MAX_LEN-1:0] body_y;
    logic [4:0]           snake_len;
    logic                 hit_wall, hit_body, apple_eaten, move_tick;

    int tests_run = 0;
    int tests_failed = 0;
    int n;

    snake_move_unit #(
        .GRID_W(8), .GRID_H(8), .MAX_LEN(MAX_LEN), .INIT_LEN(3), .MOVE_TICKS(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .game_status(game_status), .restart(restart),
        .key1_press(key1_press), .key2_press(key2_press),
        .key3_press(key3_press), .key4_press(key4_press),
        .apple_x(apple_x), .apple_y(apple_y),
        .head_x(head_x), .head_y(head_y), .body_x(body_x), .body_y(body_y),
        .snake_len(snake_len), .hit_wall(hit_wall), .hit_body(hit_body),
        .apple_eaten(apple_eaten), .move_tick(move_tick)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag, input int ex, input int ey);
        check_eq({tag, "_hx"}, 32'(head_x), ex);
        check_eq({tag, "_hy"}, 32'(head_y), ey);
    endtask

    task automatic check_seg(input string tag, input int idx, input int ex, input int ey);
        check_eq({tag, "_sx"}, 32'(body_x[6*idx +: 6]), ex);
        check_eq({tag, "_sy"}, 32'(body_y[5*idx +: 5]), ey);
    endtask

    // Returns the number of negedges until move_tick is seen high.
    task automatic wait_step(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!move_tick && cnt < 20);
        if (!move_tick) check_eq("step_timeout", 32'(move_tick), 1);
    endtask

    task automatic press(input logic [3:0] k);
        {key4_press, key3_press, key2_press, key1_press} = k;
        @(negedge clk);
        {key4_press, key3_press, key2_press, key1_press} = 4'b0000;
    endtask

    task automatic do_restart();
        restart = 1'b0;
        @(negedge clk);
        restart = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check_head("rst", 4, 4);
        check_eq("rst_len", 32'(snake_len), 3);
        check_eq("rst_wall", 32'(hit_wall), 0);
        check_eq("rst_body", 32'(hit_body), 0);
        check_eq("rst_eat", 32'(apple_eaten), 0);
        check_eq("rst_tick", 32'(move_tick), 0);
        check_seg("rst1", 1, 3, 4);
        check_seg("rst2", 2, 2, 4);
        check_seg("rst5", 5, 4, 4);

        // Straight run right into the east wall
        game_status = 2'b10;
        for (int k = 0; k < 4; k++) begin
            wait_step(n);
            check_eq("run_period", n, 4);
            if (k < 3) begin
                check_head("run", 5 + k, 4);
                check_eq("run_wall0", 32'(hit_wall), 0);
            end else begin
                check_head("wall", 7, 4);
                check_eq("wall_set", 32'(hit_wall), 1);
            end
        end
        @(negedge clk);
        check_eq("tick_pulse", 32'(move_tick), 0);
        check_eq("wall_hold", 32'(hit_wall), 1);
        game_status = 2'b11;
        do_restart();
        check_eq("rs_wall", 32'(hit_wall), 0);
        check_head("rs", 4, 4);
        check_eq("rs_len", 32'(snake_len), 3);

        // Turn down in START, then reverse key ignored
        game_status = 2'b01;
        press(4'b0010);
        game_status = 2'b10;
        wait_step(n);
        check_head("down1", 4, 5);
        press(4'b0001);
        wait_step(n);
        check_head("down2", 4, 6);
        check_seg("down2", 1, 4, 5);
        game_status = 2'b01;
        do_restart();

        // Single apple
        apple_x = 6'd5; apple_y = 5'd4;
        game_status = 2'b10;
        wait_step(n);
        check_head("eat", 5, 4);
        check_eq("eat_pulse", 32'(apple_eaten), 1);
        check_eq("eat_len", 32'(snake_len), 4);
        check_seg("eat3", 3, 2, 4);
        @(negedge clk);
        check_eq("eat_pulse_end", 32'(apple_eaten), 0);
        game_status = 2'b01;
        apple_x = 6'd7; apple_y = 5'd7;
        do_restart();

        // Length 5 loop bites its own body
        apple_x = 6'd5; apple_y = 5'd4;
        game_status = 2'b10;
        wait_step(n);
        apple_x = 6'd6;
        wait_step(n);
        check_eq("grow5_len", 32'(snake_len), 5);
        apple_x = 6'd7; apple_y = 5'd7;
        press(4'b1000); wait_step(n); check_head("l5r", 7, 4);
        press(4'b0010); wait_step(n); check_head("l5d", 7, 5);
        press(4'b0100); wait_step(n); check_head("l5l", 6, 5);
        press(4'b0001); wait_step(n);
        check_eq("l5_hit_body", 32'(hit_body), 1);
        check_eq("l5_hit_wall", 32'(hit_wall), 0);
        check_head("l5u", 6, 5);
        check_eq("l5_len", 32'(snake_len), 5);
        game_status = 2'b01;
        do_restart();
        check_eq("rs_body", 32'(hit_body), 0);

        // Length 4 loop enters the vacated tail cell
        apple_x = 6'd5; apple_y = 5'd4;
        game_status = 2'b10;
        wait_step(n);
        apple_x = 6'd7; apple_y = 5'd7;
        press(4'b1000); wait_step(n); check_head("l4r", 6, 4);
        press(4'b0010); wait_step(n); check_head("l4d", 6, 5);
        press(4'b0100); wait_step(n); check_head("l4l", 5, 5);
        press(4'b0001); wait_step(n);
        check_eq("l4_hit_body", 32'(hit_body), 0);
        check_head("l4u", 5, 4);
        check_seg("l4_3", 3, 6, 4);
        game_status = 2'b01;
        do_restart();

        // Leaving PLAY mid-count discards the partial count
        game_status = 2'b10;
        repeat (2) @(negedge clk);
        game_status = 2'b11;
        repeat (3) @(negedge clk);
        check_head("die_hold", 4, 4);
        game_status = 2'b10;
        wait_step(n);
        check_eq("reentry_period", n, 4);
        check_head("reentry", 5, 4);
        do_restart();
        check_head("rs_play", 4, 4);
        check_eq("rs_play_len", 32'(snake_len), 3);
        game_status = 2'b01;
        do_restart();

        // Simultaneous key1+key4: key1 wins
        press(4'b1001);
        game_status = 2'b10;
        wait_step(n);
        check_head("prio", 4, 3);
        game_status = 2'b01;
        do_restart();

        // LEFT is the reverse of the initial RIGHT
        press(4'b0100);
        game_status = 2'b10;
        wait_step(n);
        check_head("rev_init", 5, 4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
